// File: rtl/safe_wrapper_csr.sv
// rtl/safe_wrapper_csr.sv - safe-CPU wrapper control/status register responder
package safe_wrapper_csr_pkg;
   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } reg_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } reg_rsp_t;
endpackage

module safe_wrapper_csr
   import safe_wrapper_csr_pkg::*;
#(
   parameter int unsigned NHARTS = 3,
   parameter int unsigned AW     = 32,
   parameter int unsigned DW     = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  reg_req_t          reg_req_i,
   output reg_rsp_t          reg_rsp_o,
   output logic [1:0]        mode_o,
   output logic [NHARTS-1:0] hart_en_o,
   output logic              sync_req_o,
   input  logic [NHARTS-1:0] sync_ack_i
);

   // Top bit of the HART_EN field inside CTRL
   localparam int unsigned HI = NHARTS + 1;

   typedef enum logic {ACC_IDLE = 1'b0, ACC_RESP = 1'b1} acc_state_e;
   typedef enum logic {SY_IDLE = 1'b0, SY_WAIT = 1'b1} sync_state_e;

   acc_state_e        acc_q;
   logic [2:0]        addr_q;
   logic [1:0]        mode_q, mode_d;
   logic [NHARTS-1:0] hart_en_q, hart_en_d;
   logic [15:0]       timeout_q, timeout_d;
   logic [15:0]       errcnt_q, errcnt_d;
   logic [15:0]       cnt_q;
   logic [31:0]       scratch_q, scratch_d;
   logic              done_q, tout_q;
   sync_state_e       sync_q;
   logic              sync_req_q;

   logic [AW-1:0]     req_addr;
   logic              unused_bits;
   logic              commit;
   logic              wr_ctrl, wr_sync, wr_tmo, wr_err, wr_scr;
   logic              start, clr_done, clr_tout, ack_all, tout_hit;
   logic [31:0]       ctrl_rd, sync_rd, ctrl_wr, tmo_wr;
   logic [DW-1:0]     rdata;
   logic              rerror;

   // Byte-strobed merge of write data over the current register value
   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] wd,
                                         input logic [3:0]  strb);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) begin
         r[8*b +: 8] = strb[b] ? wd[8*b +: 8] : old[8*b +: 8];
      end
      return r;
   endfunction

   assign req_addr = reg_req_i.addr;

   // A write lands on the edge that ends the response cycle, only if valid held
   assign commit   = (acc_q == ACC_RESP) && reg_req_i.valid && reg_req_i.write;
   assign wr_ctrl  = commit && (addr_q == 3'd0);
   assign wr_sync  = commit && (addr_q == 3'd1);
   assign wr_tmo   = commit && (addr_q == 3'd2);
   assign wr_err   = commit && (addr_q == 3'd3);
   assign wr_scr   = commit && (addr_q == 3'd4);

   assign start    = wr_sync && reg_req_i.wstrb[0] && reg_req_i.wdata[0];
   assign clr_done = wr_sync && reg_req_i.wstrb[0] && reg_req_i.wdata[1];
   assign clr_tout = wr_sync && reg_req_i.wstrb[0] && reg_req_i.wdata[2];

   // Disabled harts count as acknowledged; HART_EN is sampled live
   assign ack_all  = ((sync_ack_i & hart_en_q) == hart_en_q);
   assign tout_hit = (sync_q == SY_WAIT) && !ack_all && (cnt_q == 16'd0);

   // Assemble readable views of CTRL and SYNC
   always_comb begin
      ctrl_rd       = '0;
      ctrl_rd[1:0]  = mode_q;
      ctrl_rd[HI:2] = hart_en_q;
      sync_rd       = {29'd0, tout_q, done_q, (sync_q == SY_WAIT)};
   end

   assign ctrl_wr   = merge(ctrl_rd, reg_req_i.wdata, reg_req_i.wstrb);
   assign tmo_wr    = merge({16'd0, timeout_q}, reg_req_i.wdata, reg_req_i.wstrb);
   assign mode_d    = (wr_ctrl && (ctrl_wr[1:0] != 2'd3)) ? ctrl_wr[1:0] : mode_q;
   assign hart_en_d = wr_ctrl ? ctrl_wr[HI:2] : hart_en_q;
   assign timeout_d = wr_tmo ? tmo_wr[15:0] : timeout_q;
   assign scratch_d = wr_scr ? merge(scratch_q, reg_req_i.wdata, reg_req_i.wstrb) : scratch_q;

   assign unused_bits = ^{req_addr[AW-1:5], req_addr[1:0], ctrl_wr[31:HI+1], tmo_wr[31:16]};

   // Error counter: saturating increment, byte-wise write-clear overrides it
   always_comb begin
      errcnt_d = errcnt_q;
      if (tout_hit && (errcnt_q != 16'hFFFF)) begin
         errcnt_d = errcnt_q + 16'd1;
      end
      if (wr_err && reg_req_i.wstrb[0]) begin
         errcnt_d[7:0] = 8'h00;
      end
      if (wr_err && reg_req_i.wstrb[1]) begin
         errcnt_d[15:8] = 8'h00;
      end
   end

   // Access FSM and the plain RW registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q     <= ACC_IDLE;
         addr_q    <= 3'd0;
         mode_q    <= 2'd0;
         hart_en_q <= NHARTS'(1);
         timeout_q <= 16'h00FF;
         scratch_q <= 32'd0;
      end else begin
         case (acc_q)
            ACC_IDLE: begin
               if (reg_req_i.valid) begin
                  acc_q  <= ACC_RESP;
                  addr_q <= req_addr[4:2];
               end
            end
            default: acc_q <= ACC_IDLE;
         endcase
         mode_q    <= mode_d;
         hart_en_q <= hart_en_d;
         timeout_q <= timeout_d;
         scratch_q <= scratch_d;
      end
   end

   // Sync FSM with timeout counter, sticky flags and error statistics
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q     <= SY_IDLE;
         sync_req_q <= 1'b0;
         cnt_q      <= 16'd0;
         done_q     <= 1'b0;
         tout_q     <= 1'b0;
         errcnt_q   <= 16'd0;
      end else begin
         errcnt_q <= errcnt_d;
         if (clr_done) begin
            done_q <= 1'b0;
         end
         if (clr_tout) begin
            tout_q <= 1'b0;
         end
         case (sync_q)
            SY_IDLE: begin
               if (start) begin
                  sync_q     <= SY_WAIT;
                  sync_req_q <= 1'b1;
                  cnt_q      <= timeout_q;
                  done_q     <= 1'b0;
                  tout_q     <= 1'b0;
               end
            end
            default: begin
               if (ack_all) begin
                  done_q     <= 1'b1;
                  sync_req_q <= 1'b0;
                  sync_q     <= SY_IDLE;
               end else if (cnt_q == 16'd0) begin
                  tout_q     <= 1'b1;
                  sync_req_q <= 1'b0;
                  sync_q     <= SY_IDLE;
               end else begin
                  cnt_q <= cnt_q - 16'd1;
               end
            end
         endcase
      end
   end

   // Read decode from the held address, only while responding
   always_comb begin
      rdata  = '0;
      rerror = 1'b0;
      if (acc_q == ACC_RESP) begin
         case (addr_q)
            3'd0:    rdata = ctrl_rd;
            3'd1:    rdata = sync_rd;
            3'd2:    rdata = {16'd0, timeout_q};
            3'd3:    rdata = {16'd0, errcnt_q};
            3'd4:    rdata = scratch_q;
            default: rerror = 1'b1;
         endcase
      end
   end

   assign reg_rsp_o.rdata = rdata;
   assign reg_rsp_o.error = rerror;
   assign reg_rsp_o.ready = (acc_q == ACC_RESP);
   assign mode_o          = mode_q;
   assign hart_en_o       = hart_en_q;
   assign sync_req_o      = sync_req_q;

endmodule
